bin_to_bcd_display: RTL and testbench



---
 rtl/bin_to_bcd_display_pkg.sv | 35 +++
 rtl/bin_to_bcd_display_if.sv | 25 ++
 rtl/bin_to_bcd_display_seg7_encode.sv | 19 +
 rtl/bin_to_bcd_display.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd_display.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD seven-segment display block.
// Segment constants are active-high, ordered gfedcba.
package bin_to_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Entry d holds the lit segments for decimal digit d.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned max_value(input int digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_display_if.sv
// Request/result bundle between a binary producer and the BCD display block.
// Handshake: start is a request taken on a rising clock edge only while busy
// is low; done pulses for one cycle when bcd/seg/overflow carry a new result.
interface bin_to_bcd_display_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, bin,
    input  busy, done, overflow, bcd, seg
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, bcd, seg
  );
endinterface

// File: rtl/bin_to_bcd_display_seg7_encode.sv
// One seven-segment digit: BCD digit plus blank request to gfedcba segments.
// Codes 10-15 cannot occur in a valid result and are shown blank.
module seg7_encode
  import bin_to_bcd_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] raw;

  always_comb begin
    raw = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) raw = SEG_DIGIT[digit];
    seg = SEG_ACTIVE_LOW ? ~raw : raw;
  end
endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter with registered BCD and seven-segment
// outputs; results only change when a whole conversion has completed.
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int WIDTH          = 14,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  bin_to_bcd_display_if.slave   bus,
  output state_t                dbg_state
);
  localparam int unsigned      MAX_VAL  = max_value(DIGITS);
  localparam int               CW       = $clog2(WIDTH + 1);
  localparam int               BW       = 4 * DIGITS;
  localparam int               SW       = 7 * DIGITS;
  localparam logic [SW-1:0]    SEG_OFF  = {SW{SEG_ACTIVE_LOW}};
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    cnt;
  logic             pending_ovf;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [BW-1:0]    bcd_q;
  logic [SW-1:0]    seg_q;

  logic             over;
  logic [BW-1:0]    scratch_adj;
  logic [DIGITS-1:0] blank;
  logic             zero_above;
  logic [SW-1:0]    seg_next;

  assign over = 64'(bus.bin) > 64'(MAX_VAL);

  // Add-3 correction so each digit carries correctly on the following shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (scratch[4*i +: 4] == 4'd0);
      blank[i]   = BLANK_LEADING && zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
      .digit (scratch[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_next[7*g +: 7])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      pending_ovf <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      seg_q       <= SEG_OFF;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg       <= over ? MAX_W : bus.bin;
            scratch     <= '0;
            pending_ovf <= over;
            cnt         <= CNT_LOAD;
            busy_q      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[BW-2:0], shreg[WIDTH-1]};
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          // Carry out of the top digit is impossible for a clamped value; kept as a guard.
          pending_ovf <= pending_ovf | scratch_adj[BW-1];
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= LATCH;
        end
        LATCH: begin
          bcd_q  <= scratch;
          seg_q  <= seg_next;
          ovf_q  <= pending_ovf;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
  assign bus.seg      = seg_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed bench: two instances (leading-zero blanking off/on) driven with the
// same requests; expected values are hand-computed constants.
module tb_bin_to_bcd_display;
  import bin_to_bcd_display_pkg::*;

  logic   clock;
  logic   reset;
  state_t st_a;
  state_t st_b;
  int     n_checks;
  int     n_fail;
  int     n;

  int unsigned t3_in  [4] = '{9999, 10000, 16383, 0};
  logic [15:0] t3_bcd [4] = '{16'h9999, 16'h9999, 16'h9999, 16'h0000};
  logic        t3_ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  bin_to_bcd_display_if #(.WIDTH(14), .DIGITS(4)) bus_a ();
  bin_to_bcd_display_if #(.WIDTH(14), .DIGITS(4)) bus_b ();

  bin_to_bcd_display #(.WIDTH(14), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .dbg_state(st_a)
  );
  bin_to_bcd_display #(.WIDTH(14), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .dbg_state(st_b)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic s, input logic [13:0] v);
    bus_a.start = s;
    bus_b.start = s;
    bus_a.bin   = v;
    bus_b.bin   = v;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!bus_a.done && cycles < 40);
  endtask

  // Leaves the bench in the done cycle.
  task automatic run_conv(input logic [13:0] v);
    int c;
    drive(1'b1, v);
    tick(1);
    drive(1'b0, v);
    wait_done(c);
    chk("latency", c, 15);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 14'd0);

    // 1: reset and idle
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_ovf", bus_a.overflow, 1'b0);
    chk("rst_bcd", bus_a.bcd, 16'h0000);
    chk("rst_seg_a", bus_a.seg, 28'hFFFFFFF);
    chk("rst_seg_b", bus_b.seg, 28'hFFFFFFF);
    chk("rst_state", st_a, IDLE);

    // 2: 1234 with exact busy/done timing; a start during SHIFT is ignored
    drive(1'b1, 14'd1234);
    tick(1);
    drive(1'b0, 14'd1234);
    chk("t2_busy0", bus_a.busy, 1'b1);
    chk("t2_state", st_a, SHIFT);
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) drive(1'b1, 14'd9999);
      if (i == 6) drive(1'b0, 14'd9999);
      tick(1);
      chk("t2_busy", bus_a.busy, 1'b1);
      chk("t2_done_early", bus_a.done, 1'b0);
      chk("t2_bcd_hold", bus_a.bcd, 16'h0000);
    end
    tick(1);
    chk("t2_done", bus_a.done, 1'b1);
    chk("t2_busy_done", bus_a.busy, 1'b0);
    chk("t2_bcd", bus_a.bcd, 16'h1234);
    chk("t2_hex0", bus_a.seg[6:0], 7'b0011001);
    chk("t2_hex3", bus_a.seg[27:21], 7'b1111001);
    chk("t2_seg_full", bus_a.seg, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    chk("t2_ovf", bus_a.overflow, 1'b0);
    tick(1);
    chk("t2_done_pulse", bus_a.done, 1'b0);
    tick(3);
    chk("t2_no_queue", bus_a.busy, 1'b0);
    chk("t2_bcd_kept", bus_a.bcd, 16'h1234);

    // 3: boundary values
    for (int i = 0; i < 4; i++) begin
      run_conv(14'(t3_in[i]));
      chk("t3_bcd", bus_a.bcd, t3_bcd[i]);
      chk("t3_ovf", bus_a.overflow, t3_ovf[i]);
      tick(1);
    end
    run_conv(14'd0);
    chk("t3_seg_zero", bus_a.seg, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    chk("t3_seg_nine_b", bus_b.seg[6:0], 7'b1000000);
    tick(1);

    // 4: start held high, bin changes mid-conversion
    drive(1'b1, 14'd42);
    tick(1);
    tick(2);
    drive(1'b1, 14'd77);
    wait_done(n);
    chk("t4_lat1", n, 13);
    chk("t4_bcd1", bus_a.bcd, 16'h0042);
    wait_done(n);
    chk("t4_lat2", n, 16);
    chk("t4_bcd2", bus_a.bcd, 16'h0077);
    drive(1'b0, 14'd77);
    tick(1);
    chk("t4_idle", bus_a.busy, 1'b0);

    // 5: reset in the middle of a conversion
    drive(1'b1, 14'd5678);
    tick(1);
    drive(1'b0, 14'd5678);
    tick(7);
    chk("t5_busy_pre", bus_a.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_busy", bus_a.busy, 1'b0);
    chk("t5_bcd", bus_a.bcd, 16'h0000);
    chk("t5_seg", bus_a.seg, 28'hFFFFFFF);
    chk("t5_state", st_a, IDLE);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_no_done", bus_a.done, 1'b0);
    end
    reset = 1'b1;
    tick(10);
    chk("t5_no_done_after", bus_a.done, 1'b0);
    chk("t5_idle_after", bus_a.busy, 1'b0);
    run_conv(14'd5678);
    chk("t5_bcd_after", bus_a.bcd, 16'h5678);
    tick(1);

    // 6: leading-zero blanking on instance b
    run_conv(14'd7);
    chk("t6_7_upper", bus_b.seg[27:7], {7'b1111111, 7'b1111111, 7'b1111111});
    chk("t6_7_hex0", bus_b.seg[6:0], 7'b1111000);
    chk("t6_7_bcd", bus_b.bcd, 16'h0007);
    chk("t6_7_unblanked_a", bus_a.seg[27:7], {7'b1000000, 7'b1000000, 7'b1000000});
    tick(1);
    run_conv(14'd0);
    chk("t6_0", bus_b.seg, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    tick(1);
    run_conv(14'd1005);
    chk("t6_1005", bus_b.seg, {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010});
    chk("t6_1005_bcd", bus_b.bcd, 16'h1005);
    tick(1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
